// File: rtl/scan_pkg.sv
// scan_pkg: shared decoder-enable encodings and sequencer state encoding
package scan_pkg;
    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b11;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] ACTIVE  = 1'b1;
endpackage

// File: rtl/scan_next_idx.sv
// scan_next_idx: next set mask bit above cur, wrap flag and lowest set bit
module scan_next_idx (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic       wrap,
    output logic [2:0] first
);
    always_comb begin
        nxt   = cur;
        wrap  = 1'b1;
        first = 3'd0;
        // Searching downward leaves the lowest qualifying index as the winner.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && 3'(i) > cur) begin
                nxt  = 3'(i);
                wrap = 1'b0;
            end
            if (mask[i]) first = 3'(i);
        end
    end
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: sweeps masked channels with a dwell time, driving a 3-to-8 decoder
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iMode,
    input  logic [DWELL_W-1:0] iDwell,
    input  logic [7:0]         iMask,
    output logic [2:0]         oData,
    output logic [1:0]         oEna,
    output logic               oBusy,
    output logic               oDone,
    output logic               oWrap
);
    logic [0:0]         state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d, dwell_in;
    logic [2:0]         data_q, data_d;
    logic [1:0]         ena_q, ena_d;
    logic               busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;
    logic [2:0]         nxt, in_first, unused_first, unused_nxt;
    logic               at_top, unused_wrap;

    scan_next_idx u_cur (.mask(mask_q), .cur(data_q), .nxt(nxt), .wrap(at_top), .first(unused_first));
    scan_next_idx u_in (.mask(iMask), .cur(data_q), .nxt(unused_nxt), .wrap(unused_wrap), .first(in_first));

    assign dwell_in = (iDwell == '0) ? DWELL_W'(1) : iDwell;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ena_d   = ena_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (state_q == IDLE) begin
            if (iStart && !iStop && |iMask) begin
                state_d = ACTIVE;
                mask_d  = iMask;
                dwell_d = dwell_in;
                cnt_d   = dwell_in - 1'b1;
                data_d  = in_first;
                ena_d   = ENA_ON;
                busy_d  = 1'b1;
            end
        end else if (iStop) begin
            state_d = IDLE;
            ena_d   = ENA_OFF;
            busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!at_top) begin
            data_d = nxt;
            cnt_d  = dwell_q - 1'b1;
        end else if (!iMode && |iMask) begin
            // Continuous wrap picks up a fresh mask and dwell for the next pass.
            mask_d  = iMask;
            dwell_d = dwell_in;
            cnt_d   = dwell_in - 1'b1;
            data_d  = in_first;
            wrap_d  = 1'b1;
        end else begin
            state_d = IDLE;
            ena_d   = ENA_OFF;
            busy_d  = 1'b0;
            done_d  = iMode;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dwell_q <= DWELL_W'(1);
            cnt_q   <= '0;
            data_q  <= 3'd0;
            ena_q   <= ENA_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign oData = data_q;
    assign oEna  = ena_q;
    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oWrap = wrap_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed self-checking bench for scan_sequencer
module tb_scan_sequencer;
    logic        iClk = 1'b0;
    logic        iRst_n, iStart, iStop, iMode;
    logic [15:0] iDwell;
    logic [7:0]  iMask;
    logic [2:0]  oData;
    logic [1:0]  oEna;
    logic        oBusy, oDone, oWrap;
    int          n_cmp = 0;
    int          n_err = 0;

    scan_sequencer #(.DWELL_W(16)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStop(iStop), .iMode(iMode),
        .iDwell(iDwell), .iMask(iMask), .oData(oData), .oEna(oEna), .oBusy(oBusy),
        .oDone(oDone), .oWrap(oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] d, input logic [1:0] e,
                       input logic b, input logic dn, input logic w);
        logic [7:0] obs, exp;
        obs = {oData, oEna, oBusy, oDone, oWrap};
        exp = {d, e, b, dn, w};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got data=%0d ena=%b busy=%b done=%b wrap=%b, want data=%0d ena=%b busy=%b done=%b wrap=%b",
                   tag, oData, oEna, oBusy, oDone, oWrap, d, e, b, dn, w);
        end
    endtask

    initial begin
        iRst_n = 1'b0; iStart = 1'b1; iStop = 1'b0; iMode = 1'b0; iDwell = 16'd1; iMask = 8'hFF;
        tick(); chk("rst1", 3'd0, 2'b11, 0, 0, 0);
        tick(); chk("rst2", 3'd0, 2'b11, 0, 0, 0);
        iRst_n = 1'b1; iStart = 1'b0;
        tick(); chk("rst_release_idle", 3'd0, 2'b11, 0, 0, 0);

        iMode = 1'b1; iMask = 8'hFF; iDwell = 16'd2; iStart = 1'b1;
        tick(); iStart = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("oneshot_c%0d", c), 3'(c / 2), 2'b10, 1, 0, 0);
            tick();
        end
        chk("oneshot_done", 3'd7, 2'b11, 0, 1, 0);
        tick(); chk("oneshot_done_clr", 3'd7, 2'b11, 0, 0, 0);

        iMode = 1'b0; iMask = 8'b1010_0100; iDwell = 16'd0; iStart = 1'b1;
        tick(); iStart = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("cont_k%0d", k), (k % 3 == 0) ? 3'd2 : (k % 3 == 1) ? 3'd5 : 3'd7,
                2'b10, 1, 0, (k == 3 || k == 6));
            tick();
        end
        chk("cont_k7", 3'd5, 2'b10, 1, 0, 0);
        iStop = 1'b1;
        tick(); iStop = 1'b0;
        chk("cont_stop", 3'd5, 2'b11, 0, 0, 0);

        iMask = 8'hFF; iDwell = 16'd3; iStart = 1'b1;
        tick(); iStart = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("stop_at4", 3'd4, 2'b10, 1, 0, 0);
        iStop = 1'b1;
        tick(); iStop = 1'b0;
        chk("stop_mid", 3'd4, 2'b11, 0, 0, 0);
        tick(); chk("stop_hold", 3'd4, 2'b11, 0, 0, 0);

        iMask = 8'h00; iStart = 1'b1;
        tick(); chk("start_mask0", 3'd4, 2'b11, 0, 0, 0);
        iMask = 8'hFF; iStop = 1'b1;
        tick(); chk("start_and_stop", 3'd4, 2'b11, 0, 0, 0);
        iStart = 1'b0; iStop = 1'b0;

        iMask = 8'h06; iDwell = 16'd1; iStart = 1'b1;
        tick(); iStart = 1'b0;
        chk("m0_ch1", 3'd1, 2'b10, 1, 0, 0);
        iMask = 8'h00;
        tick(); chk("m0_ch2_old", 3'd2, 2'b10, 1, 0, 0);
        tick(); chk("m0_idle", 3'd2, 2'b11, 0, 0, 0);

        iMask = 8'h0F; iStart = 1'b1;
        tick(); iStart = 1'b0;
        chk("recfg_ch0", 3'd0, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch1", 3'd1, 2'b10, 1, 0, 0);
        iMask = 8'hF0;
        tick(); chk("recfg_ch2", 3'd2, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch3", 3'd3, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch4_wrap", 3'd4, 2'b10, 1, 0, 1);
        tick(); chk("recfg_ch5", 3'd5, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch6", 3'd6, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch7", 3'd7, 2'b10, 1, 0, 0);
        tick(); chk("recfg_ch4_wrap2", 3'd4, 2'b10, 1, 0, 1);

        iStart = 1'b1;
        tick(); chk("start_ignored_active", 3'd5, 2'b10, 1, 0, 0);
        iStart = 1'b0; iRst_n = 1'b0;
        tick(); chk("rst_mid_scan", 3'd0, 2'b11, 0, 0, 0);
        iRst_n = 1'b1;
        tick(); chk("rst_mid_idle", 3'd0, 2'b11, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
